aes_uart_tx_sequencer: RTL
==========================

Name: aes_uart_tx_sequencer

Overview:
Controls the encrypt-then-transmit path. A start edge triggers one AES-128 encryption, and the block latches the 128-bit ciphertext. It then feeds the ciphertext to the UART byte transmitter as 16 bytes, MSB byte first, using a start/busy handshake. It sits between the top-level start input, the AES core and the UART TX core inside the TX top.

Parameters:
NUM_BYTES, 16, bytes per block (fixed at 16; the 128-bit width is tied to it)
GAP_CYCLES, 0, idle clk cycles inserted between consecutive bytes (0..65535)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level input; each 0->1 transition requests one block
aes_start  out  1  one-cycle pulse that launches the AES core
aes_done  in  1  AES core completion, sampled only in AES_RUN
aes_data_out  in  128  ciphertext, valid in the cycle aes_done=1
tx_data  out  8  byte presented to the UART TX core
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
tx_busy  in  1  UART TX core busy; rises the cycle after tx_start is sampled
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last byte completes
byte_idx  out  4  index of the byte in flight (0 = MSB byte)

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, on port reset, sampled on the rising edge of clk.
- Reset values: state=IDLE; aes_start=0, tx_start=0, done=0, busy=0; tx_data=0, byte_idx=0; ciphertext register=0; gap counter=0; start_d (start delay flop)=0.
- Because start_d resets to 0, a start already high when reset releases triggers exactly one block.
- Edge detect: rise = start & ~start_d, with start_d registered every cycle. A held start produces a single request.
- IDLE: on rise, go to AES_RUN and drive aes_start=1 for exactly the first AES_RUN cycle. Otherwise stay in IDLE.
- AES_RUN: wait for aes_done. On aes_done=1, latch aes_data_out into the shift register, set byte_idx=0, go to LOAD. No timeout.
- LOAD: set tx_data = shift_reg[127:120]. If tx_busy=0, go to SEND; otherwise stay in LOAD.
- SEND: tx_start=1 for this one cycle, then go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0.
  - If byte_idx=15, go to DONE.
  - Otherwise shift the register left by 8, increment byte_idx, and go to GAP (GAP_CYCLES>0) or LOAD (GAP_CYCLES=0).
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- DONE: done=1 for one cycle, then IDLE. busy is 0 from the following cycle.
- tx_data is stable from LOAD through WAIT_LO. The UART may sample it on tx_start or later.
- Start edges while busy=1 are ignored and not queued. A start edge coinciding with the DONE cycle is also ignored.
- aes_done outside AES_RUN is ignored. tx_busy edges outside the WAIT states are ignored.
- Reset mid-operation: the next cycle is IDLE with reset values. There is no partial-block resume. Any byte already in flight in the UART finishes on the line regardless.
- byte_idx wraps only via reset or the return to IDLE; it is never incremented past 15.
- Latency for GAP_CYCLES=0 and an idle UART:
  - start rise sampled at edge k -> aes_start high in cycle k+1.
  - aes_done in cycle m -> first tx_start in cycle m+2.

Decomposition:
- Shared package uart_aes_pkg holds:
  - the state encoding localparams: IDLE, AES_RUN, LOAD, SEND, WAIT_HI, WAIT_LO, GAP, DONE;
  - BLOCK_BITS=128;
  - BYTE_BITS=8.
- One natural sub-module: edge_detect_rise (start_d flop plus AND gate), reusable for other strobes.
- The FSM, shift register and gap counter stay in the top module.

Test Plan:
- Basic block: reset 10 cycles, start rise, AES model returns aes_done after 20 cycles with 0x3925841D02DC09FBDC118597196A0B32 -> tx_start pulses carry 0x39,0x25,0x84,...,0x0B,0x32 in order; exactly 16 tx_start pulses; one done pulse; busy falls the cycle after done.
- Held start: start high for 1500 cycles spanning a full block -> exactly one aes_start; no second block after done.
- Start during busy: second rise during byte 5 -> ignored. A third rise after done -> new block with fresh ciphertext 0x00112233445566778899AABBCCDDEEFF, bytes 0x00..0xFF.
- Backpressure and gap: GAP_CYCLES=3, UART holds tx_busy 100 cycles per byte, tx_busy already high at LOAD entry -> no tx_start while tx_busy=1; exactly 3 idle cycles between each tx_busy fall and the next LOAD→SEND; tx_data constant during each byte.
- Reset mid-operation: assert reset at byte_idx=7 for 1 cycle -> next cycle state IDLE with all outputs at reset values; no further tx_start; a subsequent start rise restarts from byte 0.
- Reset released with start=1: start high before and after reset deasserts -> one aes_start exactly one cycle after the first non-reset edge.

Source files
------------

// File: rtl/uart_aes_pkg.sv
// Shared types and constants for the AES encrypt-then-transmit path.
// Holds the sequencer state encoding and block/byte widths.
package uart_aes_pkg;

    localparam int BLOCK_BITS = 128;
    localparam int BYTE_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AES_RUN = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5,
        GAP     = 3'd6,
        DONE    = 3'd7
    } seq_state_e;

    // Most significant byte of a block: the next byte to go on the line.
    function automatic logic [BYTE_BITS-1:0] top_byte(
        input logic [BLOCK_BITS-1:0] blk
    );
        return blk[BLOCK_BITS-1 -: BYTE_BITS];
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one delay flop plus an AND gate.
// Delay flop clears on reset, so a level already high afterwards counts once.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Delay the level by one cycle for edge comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/aes_uart_tx_sequencer.sv
// Sequences one AES-128 encryption per start edge, then streams the
// ciphertext MSB byte first to a UART TX core using start/busy handshake.
module aes_uart_tx_sequencer
    import uart_aes_pkg::*;
#(
    parameter int NUM_BYTES  = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  aes_start,
    input  logic                  aes_done,
    input  logic [BLOCK_BITS-1:0] aes_data_out,
    output logic [BYTE_BITS-1:0]  tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            byte_idx
);

    localparam logic [3:0]  LAST_IDX = 4'(NUM_BYTES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam bit          USE_GAP  = (GAP_CYCLES > 0);

    seq_state_e            state_q, state_d;
    logic [BLOCK_BITS-1:0] shift_q, shift_d;
    logic [3:0]            idx_q, idx_d;
    logic [15:0]           gap_q, gap_d;
    logic                  aes_start_q, aes_start_d;
    logic                  start_rise;

    edge_detect_rise u_start_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (start),
        .rise  (start_rise)
    );

    // State, ciphertext shift register, byte index and gap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            aes_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            aes_start_q <= aes_start_d;
        end
    end

    // Next-state logic: encrypt, then load/send/wait per byte until done.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        aes_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d     = AES_RUN;
                    aes_start_d = 1'b1;
                end
            end
            AES_RUN: begin
                if (aes_done) begin
                    shift_d = aes_data_out;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        shift_d = shift_q << BYTE_BITS;
                        idx_d   = idx_q + 4'd1;
                        gap_d   = '0;
                        state_d = USE_GAP ? GAP : LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign aes_start = aes_start_q;
    assign tx_data   = top_byte(shift_q);
    assign tx_start  = (state_q == SEND);
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign byte_idx  = idx_q;

endmodule
